fp_to_fixed_decoder: RTL and testbench

- Consumes 32-bit results in the team float format: sign[31], exponent[30:21] (bias 511), mantissa[20:0].
- Converts each one, multi-cycle, into a signed two's-complement fixed-point word, with a status code of the same type the FPU produces.
- Sits downstream of FPU data_out. It is the decoding end of the float encoding used to drive the FPU operands, and feeds fixed-point consumers and scoreboards.
- Uses a one-bit-per-cycle iterative shifter with a valid/ready handshake on both sides.

---
 rtl/fpu_pkg.sv | 28 ++
 rtl/fp_unpack.sv | 30 +++
 rtl/fp_to_fixed_decoder.sv | 180 ++++++++++++++++++
 tb/tb_fp_to_fixed_decoder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared float format fields, status codes and field-slice helpers
package fpu_pkg;

  localparam int EXP_W = 10;
  localparam int MAN_W = 21;
  localparam int BIAS  = 511;
  localparam int FP_W  = 1 + EXP_W + MAN_W;

  typedef enum logic [3:0] {
    EXACT     = 4'd0,
    INEXACT   = 4'd1,
    UNDERFLOW = 4'd2,
    OVERFLOW  = 4'd3
  } status_t;

  function automatic logic fp_sign(input logic [FP_W-1:0] w);
    return w[FP_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] w);
    return w[FP_W-2 -: EXP_W];
  endfunction

  function automatic logic [MAN_W-1:0] fp_man(input logic [FP_W-1:0] w);
    return w[MAN_W-1:0];
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - combinational float field split, classification and shift amount
module fp_unpack
  import fpu_pkg::*;
#(
  parameter int FRAC_BITS = 16,
  parameter int K_W       = 12
) (
  input  logic [FP_W-1:0]       fp,
  output logic                  sign,
  output logic [MAN_W:0]        sig,
  output logic                  exp_zero,
  output logic                  exp_max,
  output logic                  nonzero,
  output logic signed [K_W-1:0] k
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f    = fp_exp(fp);
  assign man_f    = fp_man(fp);
  assign sign     = fp_sign(fp);
  assign sig      = {1'b1, man_f};
  assign exp_zero = (exp_f == '0);
  assign exp_max  = (exp_f == '1);
  assign nonzero  = (exp_f != '0) || (man_f != '0);
  // k is the left-shift distance from the raw significand to the Q.FRAC_BITS magnitude
  assign k = $signed({{(K_W-EXP_W){1'b0}}, exp_f}) - $signed(K_W'(BIAS + MAN_W - FRAC_BITS));

endmodule

// File: rtl/fp_to_fixed_decoder.sv
// rtl/fp_to_fixed_decoder.sv - iterative float to fixed-point converter, ROUND_NEAREST_EN selects round-to-nearest-even
module fp_to_fixed_decoder
  import fpu_pkg::*;
#(
  parameter int OUT_W      = 32,
  parameter int FRAC_BITS  = 16,
  parameter int MAX_RSHIFT = 24
) (
  input  logic             clock_100Khz,
  input  logic             reset,
  input  logic [31:0]      fp_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] fix_out,
  output logic [3:0]       status_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int K_W = 12;
  localparam int N_W = 8;
  localparam logic signed [K_W-1:0] OVF_K    = K_W'(OUT_W - 1 - MAN_W);
  localparam logic signed [K_W-1:0] MAX_RS_K = K_W'(MAX_RSHIFT);
  localparam logic [OUT_W-1:0]      SAT_MAG  = {1'b0, {(OUT_W-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, CLASSIFY, SHIFT, PACK, DONE} state_t;

  state_t           state;
  logic [31:0]      fp_q;
  logic [OUT_W-1:0] mag;
  logic [N_W-1:0]   n;
  logic             dir_left;
  logic             sticky;
  logic             sat;
  logic             neg;
  logic             nonzero_q;
  status_t          status_q;
`ifdef ROUND_NEAREST_EN
  logic             guard;
`endif

  logic                  u_sign;
  logic [MAN_W:0]        u_sig;
  logic                  u_exp_zero;
  logic                  u_exp_max;
  logic                  u_nonzero;
  logic signed [K_W-1:0] u_k;

  fp_unpack #(.FRAC_BITS(FRAC_BITS), .K_W(K_W)) u_unpack (
    .fp       (fp_q),
    .sign     (u_sign),
    .sig      (u_sig),
    .exp_zero (u_exp_zero),
    .exp_max  (u_exp_max),
    .nonzero  (u_nonzero),
    .k        (u_k)
  );

  assign in_ready   = (state == IDLE);
  assign status_out = status_q;

  logic signed [K_W-1:0] neg_k;
  logic [N_W-1:0]        n_right;

  // right-shift step count, clamped since further shifts only discard bits
  always_comb begin
    neg_k   = -u_k;
    n_right = (neg_k > MAX_RS_K) ? N_W'(MAX_RSHIFT) : N_W'(neg_k);
  end

  logic [OUT_W-1:0] mag_rnd;
  logic             inexact;
  status_t          status_next;
  logic [OUT_W-1:0] fix_next;

  // rounding, status priority and sign/saturation applied to the final magnitude
  always_comb begin
`ifdef ROUND_NEAREST_EN
    mag_rnd = mag + OUT_W'(guard & (sticky | mag[0]));
    inexact = guard | sticky;
`else
    mag_rnd = mag;
    inexact = sticky;
`endif
    status_next = EXACT;
    if (sat)                            status_next = OVERFLOW;
    else if (nonzero_q && mag_rnd == '0) status_next = UNDERFLOW;
    else if (inexact)                   status_next = INEXACT;
    if (sat) fix_next = neg ? -SAT_MAG : SAT_MAG;
    else     fix_next = neg ? -mag_rnd : mag_rnd;
  end

  // conversion state machine with registered outputs
  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fp_q      <= '0;
      mag       <= '0;
      n         <= '0;
      dir_left  <= 1'b0;
      sticky    <= 1'b0;
      sat       <= 1'b0;
      neg       <= 1'b0;
      nonzero_q <= 1'b0;
      fix_out   <= '0;
      status_q  <= EXACT;
      out_valid <= 1'b0;
`ifdef ROUND_NEAREST_EN
      guard     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            fp_q   <= fp_in;
            mag    <= '0;
            n      <= '0;
            sticky <= 1'b0;
            sat    <= 1'b0;
`ifdef ROUND_NEAREST_EN
            guard  <= 1'b0;
`endif
            state  <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          neg       <= u_sign;
          nonzero_q <= u_nonzero;
          if (u_exp_max || u_k >= OVF_K) begin
            sat   <= 1'b1;
            state <= PACK;
          end else if (u_exp_zero) begin
            mag   <= '0;
            n     <= '0;
            state <= PACK;
          end else if (!u_k[K_W-1]) begin
            mag      <= OUT_W'(u_sig);
            dir_left <= 1'b1;
            n        <= N_W'(u_k);
            state    <= (u_k == '0) ? PACK : SHIFT;
          end else begin
            mag      <= OUT_W'(u_sig);
            dir_left <= 1'b0;
            n        <= n_right;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (dir_left) begin
            mag <= mag << 1;
          end else begin
            mag <= mag >> 1;
`ifdef ROUND_NEAREST_EN
            guard  <= mag[0];
            sticky <= sticky | guard;
`else
            sticky <= sticky | mag[0];
`endif
          end
          n <= n - N_W'(1);
          if (n == N_W'(1)) state <= PACK;
        end
        PACK: begin
          fix_out   <= fix_next;
          status_q  <= status_next;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_fixed_decoder.sv
// tb/tb_fp_to_fixed_decoder.sv - scoreboard bench for fp_to_fixed_decoder, ROUND_NEAREST_EN aware
module tb_fp_to_fixed_decoder;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fp_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fix_out;
  logic [3:0]  status_out;
  logic        out_valid;
  logic        out_ready;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] fix;
    status_t     st;
    int          lat;
  } exp_t;

  exp_t sb[$];

  fp_to_fixed_decoder dut (
    .clock_100Khz (clk),
    .reset        (reset),
    .fp_in        (fp_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .fix_out      (fix_out),
    .status_out   (status_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic convert(input string tag, input logic [31:0] fp, input logic [31:0] fix,
                         input status_t st, input int lat, input int hold);
    exp_t e;
    int   cyc;
    e.fix = fix;
    e.st  = st;
    e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    fp_in    = fp;
    in_valid = 1'b1;
    chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    e = sb.pop_front();
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".latency"}, 32'(cyc), 32'(e.lat));
    chk({tag, ".fix_out"}, fix_out, e.fix);
    chk({tag, ".status"}, 32'(status_out), 32'(e.st));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      fp_in    = 32'h41200000;
      in_valid = 1'b1;
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_fix"}, fix_out, e.fix);
      chk({tag, ".hold_status"}, 32'(status_out), 32'(e.st));
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".release_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".release_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b0;
    fp_in     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.fix_out", fix_out, 32'd0);
    chk("rst.status", 32'(status_out), 32'(EXACT));
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    convert("two",      32'h40000000, 32'h00020000, EXACT,     6,  0);
    convert("zero",     32'h00000000, 32'h00000000, EXACT,     2,  0);
    convert("denorm",   32'h00000001, 32'h00000000, UNDERFLOW, 2,  0);
    convert("k_zero",   32'h40800000, 32'h00200000, EXACT,     2,  0);
    convert("k1024",    32'h41200000, 32'h04000000, EXACT,     7,  0);
    convert("k_max",    32'h41A00000, 32'h40000000, EXACT,     11, 0);
    convert("k_ovf",    32'h41C00000, 32'h7FFFFFFF, OVERFLOW,  2,  0);
    convert("ovf_pos",  32'h46000000, 32'h7FFFFFFF, OVERFLOW,  2,  0);
    convert("ovf_neg",  32'hC6000000, 32'h80000001, OVERFLOW,  2,  0);
    convert("exp_max",  32'h7FE00000, 32'h7FFFFFFF, OVERFLOW,  2,  0);
    convert("inexact",  32'h3FE00001, 32'h00010000, INEXACT,   7,  0);
    convert("udf_480",  32'h3C000000, 32'h00000000, UNDERFLOW, 26, 0);
    convert("tie_zero", 32'h3DC00000, 32'h00000000, UNDERFLOW, 24, 0);
`ifdef ROUND_NEAREST_EN
    convert("tie_odd",  32'h3FE00030, 32'h00010002, INEXACT,   7,  0);
    convert("rnd_up0",  32'h3DC00001, 32'h00000001, INEXACT,   24, 0);
`else
    convert("tie_odd",  32'h3FE00030, 32'h00010001, INEXACT,   7,  0);
    convert("rnd_up0",  32'h3DC00001, 32'h00000000, UNDERFLOW, 24, 0);
`endif
    convert("neg_bp",   32'hBFE80000, 32'hFFFEC000, EXACT,     7,  3);

    // abort a long right-shift conversion with reset
    @(negedge clk);
    fp_in    = 32'h3C000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("abort.busy", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.fix_out", fix_out, 32'd0);
    chk("abort.status", 32'(status_out), 32'(EXACT));
    chk("abort.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("abort.no_result", 32'(out_valid), 32'd0);

    convert("after_rst", 32'h40000000, 32'h00020000, EXACT,    6,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
